// File: rtl/sipo_5bit_rx.sv
// sipo_5bit_rx: serial-to-parallel word receiver with a small output FIFO and sticky error flags
module sipo_5bit_rx #(
    parameter int WIDTH     = 5,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DEPTH     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ser_in,
    input  logic             ser_en,
    input  logic             start,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sh_q, sh_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       occ_q, occ_d;
    logic              ferr_q, ferr_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]  base, shifted;
    logic              push, pop, full, wr, restart;

    // a start bit always begins from an empty register so stale bits never leak in
    assign base    = start ? '0 : sh_q;
    assign shifted = MSB_FIRST ? {base[WIDTH-2:0], ser_in} : {ser_in, base[WIDTH-1:1]};
    assign full    = occ_q == (AW+1)'(DEPTH);
    assign pop     = (occ_q != '0) && data_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        push    = 1'b0;
        restart = 1'b0;
        if (ser_en && start) begin
            restart = state_q == SHIFT;
            state_d = SHIFT;
            cnt_d   = CW'(1);
            sh_d    = shifted;
        end else if (ser_en && state_q == SHIFT) begin
            sh_d    = shifted;
            push    = cnt_q == CW'(WIDTH - 1);
            state_d = push ? IDLE : SHIFT;
            cnt_d   = push ? '0 : cnt_q + CW'(1);
        end
    end

    // a full FIFO still accepts a word when the head leaves on the same edge
    assign wr = push && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        if (wr) mem_d[wr_q] = shifted;
        wr_d   = wr ? wr_q + AW'(1) : wr_q;
        rd_d   = pop ? rd_q + AW'(1) : rd_q;
        occ_d  = occ_q + (AW+1)'(wr) - (AW+1)'(pop);
        ferr_d = restart || (ferr_q && !clr_err);
        ovf_d  = (push && full && !pop) || (ovf_q && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_out   = mem_q[rd_q];
    assign data_valid = occ_q != '0;
    assign busy       = state_q == SHIFT;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_sipo_5bit_rx.sv
// tb_sipo_5bit_rx: drives MSB-first and LSB-first receivers in parallel against a word scoreboard
module tb_sipo_5bit_rx;
    logic clk = 1'b0, rst_n = 1'b0, ser_in = 1'b0, ser_en = 1'b0, start = 1'b0;
    logic clr_err = 1'b0, data_ready = 1'b0;
    logic [4:0] do0, do1;
    logic dv0, dv1, b0, b1, fe0, fe1, ov0, ov1;
    int n_cmp = 0, n_bad = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic pend = 1'b0;
    logic [4:0] pw0 = '0, pw1 = '0;

    typedef struct {
        logic [4:0] bits;
        int         gap;
        logic [4:0] e_msb;
        logic [4:0] e_lsb;
    } vec_t;

    sipo_5bit_rx #(.WIDTH(5), .MSB_FIRST(1'b1), .DEPTH(2)) dut_m (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en), .start(start),
        .clr_err(clr_err), .data_out(do0), .data_valid(dv0), .data_ready(data_ready),
        .busy(b0), .frame_err(fe0), .overflow(ov0));

    sipo_5bit_rx #(.WIDTH(5), .MSB_FIRST(1'b0), .DEPTH(2)) dut_l (
        .clk(clk), .rst_n(rst_n), .ser_in(ser_in), .ser_en(ser_en), .start(start),
        .clr_err(clr_err), .data_out(do1), .data_valid(dv1), .data_ready(data_ready),
        .busy(b1), .frame_err(fe1), .overflow(ov1));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] rev5(input logic [4:0] w);
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_bit(input logic b, input logic st, input logic last,
                            input logic [4:0] w0, input logic [4:0] w1);
        ser_en = 1'b1;
        ser_in = b;
        start  = st;
        pend   = last;
        pw0    = w0;
        pw1    = w1;
        step();
        ser_en = 1'b0;
        start  = 1'b0;
        pend   = 1'b0;
    endtask

    task automatic send_frame(input logic [4:0] bits, input int gap,
                              input logic [4:0] e0, input logic [4:0] e1);
        for (int i = 0; i < 5; i++) begin
            send_bit(bits[4-i], i == 0, i == 4, e0, e1);
            if (i == gap) idle(3);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout_m"}, do0, 0);
        chk({tag, "_dout_l"}, do1, 0);
        chk({tag, "_valid"}, {dv0, dv1}, 0);
        chk({tag, "_busy"}, {b0, b1}, 0);
        chk({tag, "_ferr"}, {fe0, fe1}, 0);
        chk({tag, "_ovf"}, {ov0, ov1}, 0);
    endtask

    // scoreboard: words queued when their last bit is driven, popped on observed handshakes
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q0.delete();
            q1.delete();
        end else begin
            chk("valid_m", dv0, q0.size() != 0);
            chk("valid_l", dv1, q1.size() != 0);
            if (q0.size() != 0 && data_ready) begin
                chk("data_m", do0, q0.pop_front());
                chk("data_l", do1, q1.pop_front());
            end
            if (pend && q0.size() < 2) begin
                q0.push_back(pw0);
                q1.push_back(pw1);
            end
        end
    end

    initial begin
        vec_t tbl[6];
        logic [4:0] f1;
        tbl[0] = '{5'b10110, -1, 5'h16, 5'h0D};
        tbl[1] = '{5'b10110,  1, 5'h16, 5'h0D};
        tbl[2] = '{5'b11111,  2, 5'h1F, 5'h1F};
        tbl[3] = '{5'b00001, -1, 5'h01, 5'h10};
        tbl[4] = '{5'b10000,  0, 5'h10, 5'h01};
        tbl[5] = '{5'b01010,  3, 5'h0A, 5'h0A};

        idle(2);
        chk_all_zero("reset");
        rst_n = 1'b1;
        data_ready = 1'b1;
        idle(1);

        f1 = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            send_bit(f1[4-i], i == 0, i == 4, 5'h16, 5'h0D);
            if (i < 4) chk("busy_mid", {b0, b1}, 2'b11);
        end
        chk("first_valid", {dv0, dv1}, 2'b11);
        chk("first_m", do0, 5'h16);
        chk("first_l", do1, 5'h0D);
        chk("first_busy", b0, 0);
        step();
        chk("first_gone", {dv0, dv1}, 0);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i].bits, tbl[i].gap, tbl[i].e_msb, tbl[i].e_lsb);
            idle(2);
        end

        data_ready = 1'b0;
        send_frame(5'h01, -1, 5'h01, rev5(5'h01));
        send_frame(5'h02, -1, 5'h02, rev5(5'h02));
        chk("ovf_before", ov0, 0);
        send_frame(5'h03, -1, 5'h03, rev5(5'h03));
        chk("ovf_set", {ov0, ov1}, 2'b11);
        chk("ovf_head", do0, 5'h01);
        data_ready = 1'b1;
        idle(4);
        chk("ovf_drained", dv0, 0);
        chk("ovf_sticky", ov0, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ovf_clr", {ov0, ov1}, 0);

        send_bit(1'b1, 1'b1, 1'b0, 0, 0);
        send_bit(1'b0, 1'b0, 1'b0, 0, 0);
        send_bit(1'b1, 1'b0, 1'b0, 0, 0);
        chk("partial_busy", b0, 1);
        chk("no_ferr_yet", fe0, 0);
        send_frame(5'b11111, -1, 5'h1F, 5'h1F);
        chk("ferr_set", {fe0, fe1}, 2'b11);
        idle(2);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0, 0, 0);
        chk("idle_bits_busy", b0, 0);
        idle(2);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("ferr_clr", fe0, 0);

        send_bit(1'b0, 1'b1, 1'b0, 0, 0);
        send_bit(1'b1, 1'b0, 1'b0, 0, 0);
        clr_err = 1'b1;
        send_bit(1'b1, 1'b1, 1'b0, 0, 0);
        clr_err = 1'b0;
        chk("ferr_event_wins", {fe0, fe1}, 2'b11);
        send_bit(1'b1, 1'b0, 1'b0, 0, 0);
        send_bit(1'b0, 1'b0, 1'b0, 0, 0);
        send_bit(1'b0, 1'b0, 1'b0, 0, 0);
        send_bit(1'b0, 1'b0, 1'b1, 5'h18, 5'h03);
        idle(2);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        data_ready = 1'b0;
        send_frame(5'h05, -1, 5'h05, rev5(5'h05));
        send_frame(5'h06, -1, 5'h06, rev5(5'h06));
        f1 = 5'h07;
        for (int i = 0; i < 4; i++) send_bit(f1[4-i], i == 0, 1'b0, 0, 0);
        data_ready = 1'b1;
        send_bit(f1[0], 1'b0, 1'b1, 5'h07, rev5(5'h07));
        chk("pushpop_ovf", {ov0, ov1}, 0);
        chk("pushpop_head", do0, 5'h06);
        idle(4);
        chk("pushpop_drained", dv0, 0);

        data_ready = 1'b0;
        send_frame(5'h09, -1, 5'h09, rev5(5'h09));
        send_bit(1'b1, 1'b1, 1'b0, 0, 0);
        send_bit(1'b1, 1'b0, 1'b0, 0, 0);
        send_bit(1'b0, 1'b0, 1'b0, 0, 0);
        chk("pre_rst_valid", dv0, 1);
        rst_n = 1'b0;
        step();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        data_ready = 1'b1;
        send_frame(5'b10011, -1, 5'h13, 5'h19);
        chk("post_rst_m", do0, 5'h13);
        chk("post_rst_l", do1, 5'h19);
        idle(3);

        for (int i = 0; i < 20 && q0.size() != 0; i++) step();
        chk("drain", q0.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
